// File: rtl/irq_io_controller.sv
// Interrupt front-end for the processor core: edge-latches four request lines,
// dispatches the lowest pending id as a fixed-width pulse plus vector byte, and waits for EOI.
module irq_io_controller #(
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned TIMEOUT   = 200,
  parameter logic [7:0]  VEC_BASE  = 8'h80,
  parameter logic [7:0]  EOI_BASE  = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_src,
  input  logic [7:0] ext_data,
  input  logic [7:0] out_port,
  output logic       cpu_int,
  output logic [7:0] cpu_in_port,
  output logic [3:0] pending,
  output logic [1:0] active_id,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_irq_prev;
  logic [7:0] r_out_prev;
  logic [3:0] r_pending;
  logic [1:0] r_active_id;
  logic       r_cpu_int;
  logic [7:0] r_cpu_in_port;
  logic       r_busy;
  logic       r_timeout_err;
  logic [3:0] r_pulse_cnt;
  logic [7:0] r_to_cnt;

  state_t     w_state_nxt;
  logic [3:0] w_edges;
  logic [3:0] w_pend_clr;
  logic [1:0] w_sel_id;
  logic       w_eoi;
  logic [1:0] w_id_nxt;
  logic       w_int_nxt;
  logic [7:0] w_in_port_nxt;
  logic       w_busy_nxt;
  logic       w_err_nxt;
  logic [3:0] w_pulse_nxt;
  logic [7:0] w_to_nxt;

  assign w_edges = irq_src & ~r_irq_prev;
  // A write counts as EOI only when the port value changes to this source's code.
  assign w_eoi   = (out_port != r_out_prev) && (out_port == (EOI_BASE | {6'd0, r_active_id}));

  always_comb begin
    w_sel_id = 2'd0;
    if (r_pending[0])      w_sel_id = 2'd0;
    else if (r_pending[1]) w_sel_id = 2'd1;
    else if (r_pending[2]) w_sel_id = 2'd2;
    else if (r_pending[3]) w_sel_id = 2'd3;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_clr    = 4'd0;
    w_id_nxt      = r_active_id;
    w_int_nxt     = r_cpu_int;
    w_in_port_nxt = r_cpu_in_port;
    w_busy_nxt    = r_busy;
    w_err_nxt     = r_timeout_err;
    w_pulse_nxt   = r_pulse_cnt;
    w_to_nxt      = r_to_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_pending != 4'd0) begin
          w_state_nxt   = S_REQ;
          w_pend_clr    = 4'b0001 << w_sel_id;
          w_id_nxt      = w_sel_id;
          w_int_nxt     = 1'b1;
          w_in_port_nxt = VEC_BASE + {6'd0, w_sel_id};
          w_busy_nxt    = 1'b1;
          w_pulse_nxt   = 4'd0;
        end else begin
          w_in_port_nxt = ext_data;
        end
      end
      S_REQ: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_int_nxt   = 1'b0;
          w_to_nxt    = 8'd0;
          w_state_nxt = S_SERVICE;
        end else begin
          w_pulse_nxt = r_pulse_cnt + 4'd1;
        end
      end
      S_SERVICE: begin
        // EOI has priority over an expiring wait, leaving the error flag untouched.
        if (w_eoi) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_to_cnt == TO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_to_nxt = r_to_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_int_nxt   = 1'b0;
      end
    endcase
  end

  // Lines already high when reset releases must not look like fresh edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_irq_prev    <= 4'hF;
      r_out_prev    <= 8'd0;
      r_pending     <= 4'd0;
      r_active_id   <= 2'd0;
      r_cpu_int     <= 1'b0;
      r_cpu_in_port <= 8'd0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pulse_cnt   <= 4'd0;
      r_to_cnt      <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_irq_prev    <= irq_src;
      r_out_prev    <= out_port;
      r_pending     <= (r_pending & ~w_pend_clr) | w_edges;
      r_active_id   <= w_id_nxt;
      r_cpu_int     <= w_int_nxt;
      r_cpu_in_port <= w_in_port_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_err_nxt;
      r_pulse_cnt   <= w_pulse_nxt;
      r_to_cnt      <= w_to_nxt;
    end
  end

  assign cpu_int     = r_cpu_int;
  assign cpu_in_port = r_cpu_in_port;
  assign pending     = r_pending;
  assign active_id   = r_active_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_io_controller.sv
// Bench for irq_io_controller: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a timestamp-based model of the interrupt flow.
module tb_irq_io_controller;

  localparam int unsigned P  = 2;
  localparam int unsigned T  = 5;
  localparam logic [7:0]  VB = 8'h80;
  localparam logic [7:0]  EB = 8'hF0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq_src = 4'd0;
  logic [7:0] ext_data = 8'd0;
  logic [7:0] out_port = 8'd0;
  logic       cpu_int;
  logic [7:0] cpu_in_port;
  logic [3:0] pending;
  logic [1:0] active_id;
  logic       busy;
  logic       timeout_err;
  logic [1:0] dbg_state;

  irq_io_controller #(.PULSE_LEN(P), .TIMEOUT(T), .VEC_BASE(VB), .EOI_BASE(EB)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .ext_data(ext_data), .out_port(out_port),
    .cpu_int(cpu_int), .cpu_in_port(cpu_in_port), .pending(pending), .active_id(active_id),
    .busy(busy), .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an interrupt in flight is described by its dispatch edge number d.
  // The pulse covers edges d..d+P-1, service edges are d+P+1..d+P+T, timeout at d+P+T.
  logic [7:0] exp_q[$];
  logic [3:0] m_pend = 4'd0;
  logic [3:0] m_prev = 4'hF;
  logic [7:0] m_oprev = 8'd0;
  logic       m_busy = 1'b0;
  logic       m_int = 1'b0;
  logic [7:0] m_inport = 8'd0;
  logic [1:0] m_id = 2'd0;
  logic       m_err = 1'b0;
  int         t = 0;
  int         d = 0;

  initial begin
    logic [3:0] edges;
    int sel;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pend = 4'd0; m_prev = 4'hF; m_oprev = 8'd0; m_busy = 1'b0; m_int = 1'b0;
        m_inport = 8'd0; m_id = 2'd0; m_err = 1'b0;
        exp_q.delete();
      end else begin
        t = t + 1;
        edges = irq_src & ~m_prev;
        if (m_busy) begin
          if (t <= d + int'(P)) begin
            if (t == d + int'(P)) m_int = 1'b0;
          end else if ((out_port != m_oprev) && (out_port == (EB | {6'd0, m_id}))) begin
            m_busy = 1'b0;
          end else if (t == d + int'(P) + int'(T)) begin
            m_err = 1'b1;
            m_busy = 1'b0;
          end
          m_pend = m_pend | edges;
        end else if (m_pend != 4'd0) begin
          sel = 0;
          for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
          m_id = 2'(sel);
          d = t;
          m_busy = 1'b1;
          m_int = 1'b1;
          m_inport = VB + 8'(sel);
          exp_q.push_back(m_inport);
          m_pend[sel] = 1'b0;
          m_pend = m_pend | edges;
        end else begin
          m_inport = ext_data;
          m_pend = m_pend | edges;
        end
        m_prev = irq_src;
        m_oprev = out_port;
      end
    end
  end

  // Cycle compare plus vector scoreboard on every rising cpu_int.
  logic prev_int = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_cpu_int", cpu_int, m_int);
      check("cyc_in_port", cpu_in_port, m_inport);
      check("cyc_pending", pending, m_pend);
      check("cyc_active_id", active_id, m_id);
      check("cyc_busy", busy, m_busy);
      check("cyc_timeout_err", timeout_err, m_err);
      if (cpu_int && !prev_int) begin
        check("sb_vec_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_vector", cpu_in_port, exp_q.pop_front());
      end
      prev_int = cpu_int;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_int"}, cpu_int, 0);
    check({tag, "_inport"}, cpu_in_port, 0);
    check({tag, "_pend"}, pending, 0);
    check({tag, "_id"}, active_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, timeout_err, 0);
  endtask

  // driver
  initial begin
    int r;
    step(3);
    check_all_zero("reset");
    rst = 1'b1; ext_data = 8'h5A;
    step(); check("pass_5a", cpu_in_port, 8'h5A);

    // single request on id 2
    irq_src = 4'b0100;
    step(); check("single_pend", pending, 4'b0100); check("single_int_k", cpu_int, 0);
    step(); check("single_int_k1", cpu_int, 1); check("single_vec", cpu_in_port, 8'h82);
    check("single_id", active_id, 2); check("single_busy", busy, 1); check("single_clr", pending, 0);
    step(); check("single_int_k2", cpu_int, 1);
    step(); check("single_int_fall", cpu_int, 0); check("single_hold_vec", cpu_in_port, 8'h82);
    out_port = 8'hF2;
    step(); check("single_eoi", busy, 0);
    irq_src = 4'd0; out_port = 8'd0;
    step(); check("single_pass", cpu_in_port, 8'h5A);

    // priority and queueing
    irq_src = 4'b1010;
    step(2); check("prio_vec1", cpu_in_port, 8'h81); check("prio_pend", pending, 4'b1000);
    check("prio_id1", active_id, 1);
    step(2); out_port = 8'hF1;
    step(); check("prio_eoi1", busy, 0);
    step(); check("prio_int3", cpu_int, 1); check("prio_vec3", cpu_in_port, 8'h83);
    check("prio_id3", active_id, 3);
    step(2); out_port = 8'hF3;
    step(); check("prio_eoi3", busy, 0);
    irq_src = 4'd0; out_port = 8'd0;
    step();

    // wrong id ignored, then EOI for id 0
    irq_src = 4'b0001;
    step(2); check("wrong_vec0", cpu_in_port, 8'h80);
    step(2); out_port = 8'hF1;
    step(); check("wrong_id_ignored", busy, 1);
    out_port = 8'hF0;
    step(); check("right_eoi", busy, 0);
    irq_src = 4'd0;
    step();

    // EOI exactly on the expiry edge
    irq_src = 4'b0001; out_port = 8'd0;
    step(4); step(4); check("expiry_wait", busy, 1);
    out_port = 8'hF0;
    step(); check("expiry_eoi_busy", busy, 0); check("expiry_eoi_err", timeout_err, 0);
    irq_src = 4'd0;
    step();

    // timeout with out_port held at an unchanged F0
    irq_src = 4'b0001;
    step(4); step(4); check("to_wait_busy", busy, 1); check("to_wait_err", timeout_err, 0);
    step(); check("to_idle", busy, 0); check("to_err_set", timeout_err, 1);
    irq_src = 4'd0;
    step(3); check("to_err_sticky", timeout_err, 1); check("to_pass", cpu_in_port, 8'h5A);

    // re-trigger during service
    irq_src = 4'b0001; out_port = 8'd0;
    step(2); check("retrig_id", active_id, 0);
    irq_src = 4'd0;
    step(2); irq_src = 4'b0001;
    step(); check("retrig_pend", pending, 4'b0001);
    out_port = 8'hF0;
    step(); check("retrig_eoi", busy, 0); check("retrig_pend_kept", pending, 4'b0001);
    step(); check("redispatch_int", cpu_int, 1); check("redispatch_vec", cpu_in_port, 8'h80);
    check("redispatch_clr", pending, 0);
    irq_src = 4'd0; out_port = 8'd0;
    step(2); out_port = 8'hF0;
    step(); check("redispatch_eoi", busy, 0);
    step();

    // asynchronous reset in the middle of service
    irq_src = 4'b0100; out_port = 8'd0; ext_data = 8'h33;
    step(5); check("mid_busy", busy, 1);
    #2 rst = 1'b0; irq_src = 4'hF;
    #1 check_all_zero("async_rst");
    step(2);
    rst = 1'b1; ext_data = 8'h5A;
    step(); check("rel_pass", cpu_in_port, 8'h5A); check("rel_pend", pending, 0);
    step(3); check("rel_no_dispatch", busy, 0); check("rel_no_pend", pending, 0);
    irq_src = 4'd0;
    step();

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      step();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
      end
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      ext_data = 8'($urandom);
      r = $urandom_range(0, 7);
      if (r < 2) out_port = EB | 8'($urandom_range(0, 3));
      else if (r == 2) out_port = 8'($urandom);
    end
    irq_src = 4'd0;
    step(20);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
